debug_tx_framer: RTL and testbench

DEBUG_TX_FRAMER -- requirements
Module: debug_tx_framer

---
 rtl/debug_tx_framer.sv | 139 +++++++++++++
 tb/tb_debug_tx_framer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_tx_framer.sv
// Frames a 1-4 byte debug word onto a byte-wide UART transmitter, LSB first.
// Define DEBUG_TX_CHECKSUM_EN to append an XOR checksum byte after the payload.
module debug_tx_framer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [31:0] result,
  input  logic [1:0]  size,
  output logic        ready,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] shift_q;
  logic [2:0]  cnt_q;
  logic [7:0]  gap_q;
  logic        tx_start_d;
  logic        frame_end;
  logic        gap_done;

`ifdef DEBUG_TX_CHECKSUM_EN
  logic [7:0]  csum_q;
  logic        csum_sent_q;
  logic        payload_end;

  // The checksum byte is reloaded as a one-byte tail, so the frame only ends
  // once that tail has gone out.
  assign payload_end = (cnt_q == 3'd1) && !csum_sent_q;
  assign frame_end   = (cnt_q == 3'd1) &&  csum_sent_q;
`else
  assign frame_end   = (cnt_q == 3'd1);
`endif

  assign gap_done = (gap_q == 8'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (cmd_valid) state_nxt = SEND;
      SEND:      if (!tx_busy)  state_nxt = WAIT_ACK;
      WAIT_ACK:  if (tx_busy)   state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (frame_end)           state_nxt = FINISH;
          else if (GAP_CYCLES > 0) state_nxt = GAP;
          else                     state_nxt = SEND;
        end
      end
      GAP:       if (gap_done)  state_nxt = SEND;
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready      = (state == IDLE);
    done       = (state == FINISH);
    tx_start_d = (state == SEND) && !tx_busy;
  end

  // tx_start is registered, so it fires the cycle after SEND sees an idle
  // transmitter; tx_data is loaded on the same edge and held until the next byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      shift_q     <= 32'h0;
      cnt_q       <= 3'd0;
      gap_q       <= 8'h00;
`ifdef DEBUG_TX_CHECKSUM_EN
      csum_q      <= 8'h00;
      csum_sent_q <= 1'b0;
`endif
    end else begin
      tx_start <= tx_start_d;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            shift_q     <= result;
            cnt_q       <= {1'b0, size} + 3'd1;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_q      <= 8'h00;
            csum_sent_q <= 1'b0;
`endif
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data <= shift_q[7:0];
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_q  <= csum_q ^ shift_q[7:0];
`endif
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            gap_q <= 8'h00;
`ifdef DEBUG_TX_CHECKSUM_EN
            if (payload_end) begin
              shift_q     <= {24'h0, csum_q};
              cnt_q       <= 3'd1;
              csum_sent_q <= 1'b1;
            end else begin
              shift_q <= {8'h00, shift_q[31:8]};
              cnt_q   <= cnt_q - 3'd1;
            end
`else
            shift_q <= {8'h00, shift_q[31:8]};
            cnt_q   <= cnt_q - 3'd1;
`endif
          end
        end
        GAP:     gap_q <= gap_q + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_tx_framer.sv
// Self-checking bench for debug_tx_framer: a UART busy model records every
// started byte; each test pushes the bytes it expects and compares after done.
module tb_debug_tx_framer;

  localparam int BUSY_CYC = 10;
  localparam int TIMEOUT  = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [31:0] result;
  logic [1:0]  size;
  logic        ready;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        done;

  logic        uart_busy = 1'b0;
  logic        hold_busy;
  int          uart_cnt = 0;
  logic [7:0]  obs_q[$];
  logic [7:0]  exp_q[$];
  int          obs_rd = 0;
  int          done_cnt = 0;
  int          viol_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign tx_busy = uart_busy | hold_busy;

  debug_tx_framer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .result    (result),
    .size      (size),
    .ready     (ready),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .done      (done)
  );

  // UART model: busy for BUSY_CYC cycles per accepted byte; also flags
  // tx_start overlapping tx_busy or done.
  always @(negedge clk) begin
    if (uart_cnt > 0) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_busy <= 1'b0;
    end else if (tx_start) begin
      obs_q.push_back(tx_data);
      uart_busy <= 1'b1;
      uart_cnt  <= BUSY_CYC;
    end
    if ((tx_start && tx_busy) || (tx_start && done)) viol_cnt <= viol_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic send_cmd(input logic [31:0] res, input logic [1:0] sz);
`ifdef DEBUG_TX_CHECKSUM_EN
    logic [7:0] cs = 8'h00;
`endif
    for (int i = 0; i <= int'(sz); i++) begin
      exp_q.push_back(res[8*i +: 8]);
`ifdef DEBUG_TX_CHECKSUM_EN
      cs ^= res[8*i +: 8];
`endif
    end
`ifdef DEBUG_TX_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    @(negedge clk);
    result    = res;
    size      = sz;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < TIMEOUT; c++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ready, tx_start, tx_data, done} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got r=%b s=%b d=%h dn=%b, expected r=1 s=0 d=00 dn=0",
               ready, tx_start, tx_data, done);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (ready !== 1'b1 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b tx_start=%b expected 1/0", ready, tx_start);
    end
  endtask

  task automatic test_deadbeef();
    int d0 = done_cnt;
    bit ok;
    logic [7:0] e;
    send_cmd(32'hDEADBEEF, 2'b11);
    #1;
    checks++;
    if (tx_start !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got tx_start=%b ready=%b expected 0/0", tx_start, ready);
    end
    @(negedge clk); #1;
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'hEF) begin
      errors++;
      $display("FAIL latency_first: got tx_start=%b tx_data=%h expected 1/ef", tx_start, tx_data);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL deadbeef_timeout: got no done expected done"); end
    repeat (3) @(negedge clk); #1;
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL deadbeef_done_count: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (obs_q.size() - obs_rd !== exp_q.size()) begin
      errors++;
      $display("FAIL deadbeef_byte_count: got %0d expected %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size() || obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL deadbeef_byte: got %h expected %h", (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx, e);
      end
      obs_rd++;
    end
    obs_rd = obs_q.size();
    checks++;
    if (viol_cnt !== 0) begin errors++; $display("FAIL deadbeef_protocol: got %0d violations expected 0", viol_cnt); end
  endtask

  task automatic test_single_byte();
    int d0 = done_cnt;
    bit ok;
    logic [7:0] e;
    send_cmd(32'h00000055, 2'b00);
    wait_done(ok);
    checks++;
    if (!ok || ready !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got done_seen=%b ready=%b expected 1/0", ok, ready);
    end
    @(negedge clk); #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_after_done: got ready=%b done=%b expected 1/0", ready, done);
    end
    repeat (20) @(negedge clk); #1;
    checks++;
    if (done_cnt - d0 !== 1 || obs_q.size() - obs_rd !== exp_q.size()) begin
      errors++;
      $display("FAIL single_counts: got done=%0d bytes=%0d expected 1/%0d",
               done_cnt - d0, obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size() || obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL single_byte: got %h expected %h", (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx, e);
      end
      obs_rd++;
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_ignore();
    int d0 = done_cnt;
    bit ok;
    logic [7:0] e;
    send_cmd(32'hCAFEF00D, 2'b11);
    for (int c = 0; c < 200 && obs_q.size() <= obs_rd; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL ignore_ready: got %b expected 0", ready); end
    result    = 32'h12345678;
    size      = 2'b00;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ignore_timeout: got no done expected done"); end
    repeat (30) @(negedge clk); #1;
    checks++;
    if (done_cnt - d0 !== 1 || obs_q.size() - obs_rd !== exp_q.size()) begin
      errors++;
      $display("FAIL ignore_counts: got done=%0d bytes=%0d expected 1/%0d",
               done_cnt - d0, obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size() || obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL ignore_byte: got %h expected %h", (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx, e);
      end
      obs_rd++;
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_busy_hold();
    int s0;
    bit ok;
    logic [7:0] e;
    @(negedge clk);
    hold_busy = 1'b1;
    send_cmd(32'h000000A7, 2'b00);
    s0 = obs_q.size();
    repeat (50) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() !== s0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL busy_hold_start: got %0d starts expected 0", obs_q.size() - s0);
    end
    hold_busy = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_hold_timeout: got no done expected done"); end
    repeat (3) @(negedge clk); #1;
    checks++;
    if (obs_q.size() - obs_rd !== exp_q.size()) begin
      errors++;
      $display("FAIL busy_hold_byte_count: got %0d expected %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size() || obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL busy_hold_byte: got %h expected %h", (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx, e);
      end
      obs_rd++;
    end
    obs_rd = obs_q.size();
    checks++;
    if (viol_cnt !== 0) begin errors++; $display("FAIL busy_hold_protocol: got %0d violations expected 0", viol_cnt); end
  endtask

  task automatic test_reset_midframe();
    int d0 = done_cnt;
    int s_rst;
    bit ok;
    logic [7:0] e;
    send_cmd(32'h44332211, 2'b11);
    for (int c = 0; c < 200 && obs_q.size() - obs_rd < 2; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ready, tx_start, tx_data, done} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset_values: got r=%b s=%b d=%h dn=%b expected 1/0/00/0",
               ready, tx_start, tx_data, done);
    end
    s_rst = obs_q.size();
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    repeat (40) @(negedge clk); #1;
    checks++;
    if (obs_q.size() !== s_rst || done_cnt !== d0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL midframe_abort: got %0d extra starts, %0d dones, ready=%b expected 0/0/1",
               obs_q.size() - s_rst, done_cnt - d0, ready);
    end
    checks++;
    if (s_rst - obs_rd !== 2) begin
      errors++;
      $display("FAIL midframe_bytes_before_reset: got %0d expected 2", s_rst - obs_rd);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size() || obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL midframe_byte: got %h expected %h", (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx, e);
      end
      obs_rd++;
    end
    exp_q.delete();
    obs_rd = obs_q.size();
    send_cmd(32'h000000C3, 2'b01);
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL after_reset_timeout: got no done expected done"); end
    repeat (3) @(negedge clk); #1;
    checks++;
    if (obs_q.size() - obs_rd !== exp_q.size()) begin
      errors++;
      $display("FAIL after_reset_byte_count: got %0d expected %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size() || obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL after_reset_byte: got %h expected %h", (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx, e);
      end
      obs_rd++;
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_two_byte();
    int d0 = done_cnt;
    bit ok;
    logic [7:0] e;
    send_cmd(32'h0000A53C, 2'b01);
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL two_byte_timeout: got no done expected done"); end
    repeat (3) @(negedge clk); #1;
    checks++;
    if (done_cnt - d0 !== 1 || obs_q.size() - obs_rd !== exp_q.size()) begin
      errors++;
      $display("FAIL two_byte_counts: got done=%0d bytes=%0d expected 1/%0d",
               done_cnt - d0, obs_q.size() - obs_rd, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size() || obs_q[obs_rd] !== e) begin
        errors++;
        $display("FAIL two_byte: got %h expected %h", (obs_rd < obs_q.size()) ? obs_q[obs_rd] : 8'hxx, e);
      end
      obs_rd++;
    end
    obs_rd = obs_q.size();
    checks++;
    if (viol_cnt !== 0) begin errors++; $display("FAIL final_protocol: got %0d violations expected 0", viol_cnt); end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    result    = 32'h0;
    size      = 2'b00;
    hold_busy = 1'b0;
    test_reset();
    test_deadbeef();
    test_single_byte();
    test_ignore();
    test_busy_hold();
    test_reset_midframe();
    test_two_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
